// File: rtl/display_bcd_sequencer.sv
// 7-segment decimal display front end: signed write -> iterative double-dabble
// BCD conversion, with a held display register updated atomically on completion.
module display_bcd_sequencer #(
  parameter int WIDTH         = 32,
  parameter int DIGITS        = 10,
  parameter int BLANK_LEADING = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [WIDTH-1:0]          wr_data,
  output logic                      busy,
  output logic                      done,
  output logic [7*(DIGITS+1)-1:0]   seg,
  output logic                      dot
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t          state;
  logic [WIDTH-1:0] bin;
  logic [BW-1:0]    work_bcd;
  logic [BW-1:0]    adj;
  logic             neg_work;
  logic [CW-1:0]    cnt;
  logic             pend_valid;
  logic [WIDTH-1:0] pend_data;
  logic [WIDTH-1:0] start_val;
  logic [BW-1:0]    display_bcd;
  logic             display_neg;
  logic [3:0]       nib;
  logic             upper_zero;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [6:0] digit_pat(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // A live write takes priority over the buffered one (newest wins).
  assign start_val = wr_en ? wr_data : pend_data;

  always_comb begin
    adj = work_bcd;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (work_bcd[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = work_bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      bin         <= '0;
      work_bcd    <= '0;
      neg_work    <= 1'b0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pend_valid  <= 1'b0;
      pend_data   <= '0;
      display_bcd <= '0;
      display_neg <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (wr_en || pend_valid) begin
            bin        <= magnitude(start_val);
            neg_work   <= start_val[WIDTH-1];
            work_bcd   <= '0;
            cnt        <= '0;
            busy       <= 1'b1;
            pend_valid <= 1'b0;
            state      <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          {work_bcd, bin} <= {adj[BW-2:0], bin, 1'b0};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1))
            state <= S_DONE;
          if (wr_en) begin
            pend_data  <= wr_data;
            pend_valid <= 1'b1;
          end
        end
        S_DONE: begin
          display_bcd <= work_bcd;
          display_neg <= neg_work;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= S_IDLE;
          if (wr_en) begin
            pend_data  <= wr_data;
            pend_valid <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Scan from the top digit down so a digit blanks only while everything above it is zero.
  always_comb begin
    seg        = '1;
    nib        = '0;
    upper_zero = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      nib        = display_bcd[4*(DIGITS-1-k) +: 4];
      upper_zero = upper_zero && (nib == 4'd0);
      if (BLANK_LEADING != 0 && upper_zero && k != DIGITS - 1)
        seg[7*(DIGITS-1-k) +: 7] = 7'h7F;
      else
        seg[7*(DIGITS-1-k) +: 7] = ~digit_pat(nib);
    end
    seg[7*DIGITS +: 7] = (display_neg && (|display_bcd)) ? ~7'h40 : 7'h7F;
  end

  assign dot = 1'b1;

endmodule

// File: tb/tb_display_bcd_sequencer.sv
// Scoreboard bench for display_bcd_sequencer: expected segment images are queued
// at write time and compared whenever the DUT pulses done.
module tb_display_bcd_sequencer;

  localparam int WIDTH  = 32;
  localparam int DIGITS = 10;
  localparam int SW     = 7 * (DIGITS + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             busy, done, dot;
  logic [SW-1:0]    seg;
  logic             busy0, done0, dot0;
  logic [SW-1:0]    seg0;

  int checks = 0;
  int fails  = 0;
  logic [SW-1:0] exp_q[$];

  display_bcd_sequencer #(.WIDTH(WIDTH), .DIGITS(DIGITS), .BLANK_LEADING(1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .busy(busy), .done(done), .seg(seg), .dot(dot)
  );

  display_bcd_sequencer #(.WIDTH(WIDTH), .DIGITS(DIGITS), .BLANK_LEADING(0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .busy(busy0), .done(done0), .seg(seg0), .dot(dot0)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  default: return 7'h6F;
    endcase
  endfunction

  // Decimal reference image built with divide/modulo.
  function automatic logic [SW-1:0] model(input longint v, input bit blank);
    longint m;
    int d[DIGITS];
    int msd;
    logic [SW-1:0] r;
    m   = (v < 0) ? -v : v;
    msd = 0;
    for (int k = 0; k < DIGITS; k++) begin
      d[k] = int'(m % 10);
      m    = m / 10;
      if (d[k] != 0) msd = k;
    end
    for (int k = 0; k < DIGITS; k++)
      r[7*k +: 7] = (blank && k > msd) ? 7'h7F : ~pat(d[k]);
    r[7*DIGITS +: 7] = (v < 0) ? 7'h3F : 7'h7F;
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected_done: done=1 with empty queue, seg=%h", seg);
      end else begin
        logic [SW-1:0] e;
        e = exp_q.pop_front();
        if (seg !== e) begin
          fails++;
          $display("FAIL sb_seg: got %h expected %h", seg, e);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic do_write(input longint v);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = WIDTH'(v);
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL wait_done: no done within %0d cycles, got %b expected 1", n, done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b1; wr_data = 32'd5;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL reset_flags: busy=%b done=%b expected 0 0", busy, done);
    end
    checks++;
    if (seg !== model(0, 1'b1)) begin
      fails++; $display("FAIL reset_seg: got %h expected %h", seg, model(0, 1'b1));
    end
    checks++;
    if (seg0 !== model(0, 1'b0)) begin
      fails++; $display("FAIL reset_seg_noblank: got %h expected %h", seg0, model(0, 1'b0));
    end
    checks++;
    if (dot !== 1'b1) begin
      fails++; $display("FAIL reset_dot: got %b expected 1", dot);
    end
    rst = 1'b0; wr_en = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
        fails++; $display("FAIL reset_no_start: busy=%b expected 0", busy);
      end
    end
  endtask

  task automatic test_basic();
    logic [SW-1:0] old;
    old = model(0, 1'b1);
    exp_q.push_back(model(12345, 1'b1));
    do_write(12345);
    checks++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL basic_busy_e0: got %b expected 1", busy);
    end
    for (int e = 1; e <= WIDTH; e++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || seg !== old) begin
        fails++;
        $display("FAIL basic_hold_e%0d: busy=%b done=%b seg=%h expected 1 0 %h", e, busy, done, seg, old);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL basic_done_e33: done=%b busy=%b expected 1 0", done, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      fails++; $display("FAIL basic_done_pulse: done=%b expected 0", done);
    end
  endtask

  task automatic test_extremes();
    exp_q.push_back(model(-64'sd2147483648, 1'b1));
    do_write(-64'sd2147483648);
    wait_done();
    exp_q.push_back(model(-1, 1'b1));
    do_write(-1);
    wait_done();
    @(negedge clk);
    checks++;
    if (seg[7*DIGITS +: 7] !== 7'h3F || seg[6:0] !== ~7'h06) begin
      fails++; $display("FAIL neg_one_fields: sign=%h d0=%h expected 3f %h", seg[7*DIGITS +: 7], seg[6:0], ~7'h06);
    end
  endtask

  task automatic test_zero();
    exp_q.push_back(model(0, 1'b1));
    do_write(0);
    wait_done();
    @(negedge clk);
    checks++;
    if (seg0 !== model(0, 1'b0)) begin
      fails++; $display("FAIL zero_noblank: got %h expected %h", seg0, model(0, 1'b0));
    end
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(model(7, 1'b1));
    exp_q.push_back(model(200, 1'b1));
    do_write(7);
    repeat (4) @(negedge clk);
    wr_en = 1'b1; wr_data = 32'd100;
    @(negedge clk);
    wr_en = 1'b0;
    repeat (14) @(negedge clk);
    wr_en = 1'b1; wr_data = 32'd200;
    @(negedge clk);
    wr_en = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      fails++; $display("FAIL b2b_e32: busy=%b done=%b expected 1 0", busy, done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL b2b_first_done: done=%b busy=%b expected 1 0", done, busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || seg !== model(7, 1'b1)) begin
      fails++; $display("FAIL b2b_restart: busy=%b done=%b seg=%h expected 1 0 %h", busy, done, seg, model(7, 1'b1));
    end
    wait_done();
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    do_write(999);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || seg !== model(0, 1'b1)) begin
      fails++; $display("FAIL abort_state: busy=%b done=%b seg=%h expected 0 0 %h", busy, done, seg, model(0, 1'b1));
    end
    repeat (50) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        fails++; $display("FAIL abort_quiet: busy=%b done=%b expected 0 0", busy, done);
      end
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = '0;
    test_reset();
    test_basic();
    test_extremes();
    test_zero();
    test_back_to_back();
    test_reset_abort();
    checks++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL sb_leftover: %0d entries remain, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
